// File: rtl/obi_wb_pkg.sv
// Shared types and helpers for the OBI to Wishbone pipelined bridge.
package obi_wb_pkg;

    // Wishbone-side transfer sequencer states.
    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_BUSY = 2'd1,
        WB_RESP = 2'd2
    } wb_state_e;

    // Widest address the window helper can compare.
    localparam int unsigned MAX_ADDR_W = 64;

    // True when addr[addr_w-1:lsb] equals base[addr_w-1:lsb].
    function automatic logic addr_in_window(input logic [MAX_ADDR_W-1:0] addr,
                                            input logic [MAX_ADDR_W-1:0] base,
                                            input int unsigned           addr_w,
                                            input int unsigned           lsb);
        logic hit;
        hit = 1'b1;
        for (int unsigned i = 0; i < MAX_ADDR_W; i++) begin
            if ((i >= lsb) && (i < addr_w) && (addr[i] != base[i])) begin
                hit = 1'b0;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/obi_wb_cmd_fifo.sv
// Synchronous command FIFO with fall-through head; pointers carry a wrap bit.
module obi_wb_cmd_fifo
    import obi_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IW:0]      wr_q, wr_d;
    logic [IW:0]      rd_q, rd_d;
    logic             push_ok, pop_ok;

    // Advance within DEPTH entries, toggling the wrap bit at the end.
    function automatic logic [IW:0] ptr_inc(input logic [IW:0] p);
        if (p[IW-1:0] == IW'(DEPTH - 1)) begin
            return {~p[IW], {IW{1'b0}}};
        end
        return p + 1'b1;
    endfunction

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[IW] != rd_q[IW]) && (wr_q[IW-1:0] == rd_q[IW-1:0]);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_q[IW-1:0]];

    // Next pointer values.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) wr_d = ptr_inc(wr_q);
        if (pop_ok)  rd_d = ptr_inc(rd_q);
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q[IW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/obi_wb_pipe_bridge.sv
// Single-clock OBI slave to Wishbone classic master with queued requests,
// address-window decode, error propagation and a bus timeout.
module obi_wb_pipe_bridge
    import obi_wb_pkg::*;
#(
    parameter int unsigned       ADDR_W          = 32,
    parameter int unsigned       DATA_W          = 32,
    parameter int unsigned       WB_ADDR_W       = 20,
    parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
    parameter int unsigned       FIFO_DEPTH      = 2,
    parameter int unsigned       MAX_OUTSTANDING = 2,
    parameter int unsigned       TIMEOUT_CYCLES  = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en,
    input  logic                obi_req_i,
    output logic                obi_gnt_o,
    input  logic [ADDR_W-1:0]   obi_addr_i,
    input  logic                obi_wr_en_i,
    input  logic [DATA_W/8-1:0] obi_byte_en_i,
    input  logic [DATA_W-1:0]   obi_wdata_i,
    output logic                obi_rvalid_o,
    output logic [DATA_W-1:0]   obi_rdata_o,
    output logic                obi_err_o,
    output logic [ADDR_W-1:0]   wb_addr_o,
    input  logic [DATA_W-1:0]   wb_rdata_i,
    output logic [DATA_W-1:0]   wb_wdata_o,
    output logic                wb_wr_en_o,
    output logic [DATA_W/8-1:0] wb_byte_en_o,
    output logic                wb_stb_o,
    output logic                wb_cyc_o,
    input  logic                wb_ack_i,
    input  logic                wb_err_i
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam int unsigned OW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    // Command entry; kept local because a package cannot be parametrised.
    // The address is truncated to the forwarded bits before queuing.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic              we;
        logic              dec_err;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

    cmd_t             push_cmd, head_cmd;
    logic [CMD_W-1:0] head_bits;
    logic             fifo_full, fifo_empty, fifo_pop;

    wb_state_e         state_q, state_d;
    logic [OW-1:0]     outstanding_q, outstanding_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              we_q, we_d;
    logic              cyc_q, cyc_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    assign obi_gnt_o = obi_req_i && en && !fifo_full && (outstanding_q < MAX_OUT);

    assign push_cmd.addr    = ADDR_W'(obi_addr_i[WB_ADDR_W-1:0]);
    assign push_cmd.wdata   = obi_wdata_i;
    assign push_cmd.be      = obi_byte_en_i;
    assign push_cmd.we      = obi_wr_en_i;
    assign push_cmd.dec_err = !addr_in_window(64'(obi_addr_i), 64'(BASE_ADDR), ADDR_W, WB_ADDR_W);
    assign head_cmd         = cmd_t'(head_bits);

    obi_wb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (obi_gnt_o),
        .wdata_i (push_cmd),
        .pop_i   (fifo_pop),
        .rdata_o (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Granted-but-unanswered request count.
    always_comb begin
        outstanding_d = outstanding_q;
        case ({obi_gnt_o, rvalid_q})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Wishbone sequencer: next state and registered bus/response values.
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        timer_d  = timer_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        we_d     = we_q;
        cyc_d    = cyc_q;
        rvalid_d = 1'b0;
        err_d    = err_q;
        rdata_d  = rdata_q;
        case (state_q)
            WB_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_cmd.dec_err) begin
                        state_d  = WB_RESP;
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                        rdata_d  = '0;
                    end else begin
                        state_d = WB_BUSY;
                        cyc_d   = 1'b1;
                        addr_d  = head_cmd.addr;
                        wdata_d = head_cmd.wdata;
                        be_d    = head_cmd.be;
                        we_d    = head_cmd.we;
                        timer_d = '0;
                    end
                end
            end
            WB_BUSY: begin
                if (timer_q != '1) timer_d = timer_q + 1'b1;
                if (wb_err_i) begin
                    state_d  = WB_RESP;
                    cyc_d    = 1'b0;
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    rdata_d  = '0;
                end else if (wb_ack_i) begin
                    state_d  = WB_RESP;
                    cyc_d    = 1'b0;
                    rvalid_d = 1'b1;
                    err_d    = 1'b0;
                    rdata_d  = we_q ? '0 : wb_rdata_i;
                end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TO_LAST)) begin
                    state_d  = WB_RESP;
                    cyc_d    = 1'b0;
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    rdata_d  = '0;
                end
            end
            WB_RESP: begin
                state_d = WB_IDLE;
            end
            default: begin
                state_d = WB_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= WB_IDLE;
            outstanding_q <= '0;
            timer_q       <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            we_q          <= 1'b0;
            cyc_q         <= 1'b0;
            rvalid_q      <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            timer_q       <= timer_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            we_q          <= we_d;
            cyc_q         <= cyc_d;
            rvalid_q      <= rvalid_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
        end
    end

    assign wb_addr_o    = addr_q;
    assign wb_wdata_o   = wdata_q;
    assign wb_byte_en_o = be_q;
    assign wb_wr_en_o   = we_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign obi_rvalid_o = rvalid_q;
    assign obi_err_o    = err_q;
    assign obi_rdata_o  = rdata_q;

endmodule
